// File: rtl/adc_pkg.sv
// Shared field positions, widths and types for the LTC2494 receive-side decoder.
// Result decode lives here so the entry layout and the flag rules stay in one place.
package adc_pkg;

  localparam int unsigned CMD_PRE_HI = 31;
  localparam int unsigned CMD_PRE_LO = 30;
  localparam int unsigned CMD_EN     = 29;
  localparam int unsigned CMD_CH_HI  = 28;
  localparam int unsigned CMD_CH_LO  = 24;
  localparam int unsigned CMD_EN2    = 23;
  localparam int unsigned CMD_GS_HI  = 18;
  localparam int unsigned CMD_GS_LO  = 16;
  localparam logic [1:0]  PREAMBLE   = 2'b10;

  localparam int unsigned RX_EOC_N = 31;
  localparam int unsigned RX_DMY   = 30;
  localparam int unsigned RX_SIG   = 29;
  localparam int unsigned RX_D_HI  = 28;
  localparam int unsigned RX_D_LO  = 12;

  localparam int unsigned CFG_W   = 8;
  localparam int unsigned RES_W   = 18;
  localparam int unsigned CHAN_W  = 5;
  localparam int unsigned GAIN_W  = 3;
  localparam int unsigned ENTRY_W = RES_W + CHAN_W + GAIN_W + 2;

  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic [GAIN_W-1:0] gain;
  } cfg_t;

  typedef struct packed {
    logic [RES_W-1:0]  result;
    logic [CHAN_W-1:0] chan;
    logic [GAIN_W-1:0] gain;
    logic              ovr;
    logic              unr;
  } entry_t;

  typedef enum logic {UNPRIMED, PRIMED} state_t;

  // SIG is the inverted sign: flipping it turns the offset-binary word into two's complement.
  function automatic entry_t make_entry(input logic [31:0] rx, input cfg_t tag);
    entry_t      e;
    logic        sig;
    logic [16:0] d;
    sig      = rx[RX_SIG];
    d        = rx[RX_D_HI:RX_D_LO];
    e.result = {~sig, d};
    e.chan   = tag.chan;
    e.gain   = tag.gain;
    e.ovr    = sig & d[16];
    e.unr    = ~sig & ~d[16];
    return e;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through FIFO; head data holds the last popped entry while empty.
// Push into a full FIFO succeeds only when a pop happens in the same cycle.
module result_fifo #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  output logic             full
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] hold;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             pop;
  logic             wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ready & ~empty;
  assign wr_en = push & (~full | pop);
  assign valid = ~empty;
  assign rdata = empty ? hold : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        hold   <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/adc_result_decoder.sv
// LTC2494 receive-side decoder: tags each returned conversion with the config that produced it.
// Define ADC_RX_ERRCNT_EN to add o_ERRCNT, a saturating count of malformed result words.
module adc_result_decoder
  import adc_pkg::*;
#(
  parameter int unsigned       DEPTH   = 4,
  parameter logic [CFG_W-1:0]  CFG_RST = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_xferDone,
  input  logic [31:0] i_TXDATA,
  input  logic [31:0] i_RXDATA,
  input  logic        i_resReady,
  output logic        o_resValid,
  output logic [17:0] o_RESULT,
  output logic [4:0]  o_CHAN,
  output logic [2:0]  o_GAIN,
  output logic        o_OVR,
  output logic        o_UNR,
  output logic        o_overflow
`ifdef ADC_RX_ERRCNT_EN
  ,
  output logic [15:0] o_ERRCNT
`endif
);

  state_t               state_q;
  state_t               state_d;
  cfg_t                 cfg_q;
  entry_t               head;
  entry_t               new_entry;
  logic [ENTRY_W-1:0]   head_bits;
  logic                 cmd_apply;
  logic                 fmt_ok;
  logic                 push;
  logic                 full;
  logic                 pop;
  logic                 unused_bits;

  assign cmd_apply = (i_TXDATA[CMD_PRE_HI:CMD_PRE_LO] == PREAMBLE) && i_TXDATA[CMD_EN];
  assign fmt_ok    = ~i_RXDATA[RX_EOC_N] & ~i_RXDATA[RX_DMY];
  assign new_entry = make_entry(i_RXDATA, cfg_q);
  assign pop       = o_resValid & i_resReady;
  assign unused_bits = ^{i_TXDATA[22:19], i_TXDATA[15:0], i_RXDATA[11:0]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= UNPRIMED;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      UNPRIMED: if (i_xferDone && cmd_apply) state_d = PRIMED;
      PRIMED:   push = i_xferDone & fmt_ok;
      default:  state_d = UNPRIMED;
    endcase
  end

  // cfg_q updates after the tag has been taken from it, so a result carries the older config.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= cfg_t'(CFG_RST);
    end else if (i_xferDone && cmd_apply) begin
      cfg_q.chan <= i_TXDATA[CMD_CH_HI:CMD_CH_LO];
      if (i_TXDATA[CMD_EN2]) cfg_q.gain <= i_TXDATA[CMD_GS_HI:CMD_GS_LO];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                      o_overflow <= 1'b0;
    else if (push && full && !pop) o_overflow <= 1'b1;
  end

  result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (new_entry),
    .ready (i_resReady),
    .valid (o_resValid),
    .rdata (head_bits),
    .full  (full)
  );

  assign head     = entry_t'(head_bits);
  assign o_RESULT = head.result;
  assign o_CHAN   = head.chan;
  assign o_GAIN   = head.gain;
  assign o_OVR    = head.ovr;
  assign o_UNR    = head.unr;

`ifdef ADC_RX_ERRCNT_EN
  logic [15:0] errcnt;

  always_ff @(posedge clk) begin
    if (rst)                                       errcnt <= '0;
    else if (i_xferDone && !fmt_ok && errcnt != '1) errcnt <= errcnt + 16'd1;
  end

  assign o_ERRCNT = errcnt;
`endif

endmodule

// File: tb/tb_adc_result_decoder.sv
// Scoreboard bench for adc_result_decoder: driver predicts results, negedge monitor checks pops.
// Covers ADC_RX_ERRCNT_EN when the macro is defined for the build.
module tb_adc_result_decoder;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_xferDone;
  logic [31:0] i_TXDATA;
  logic [31:0] i_RXDATA;
  logic        i_resReady;
  logic        o_resValid;
  logic [17:0] o_RESULT;
  logic [4:0]  o_CHAN;
  logic [2:0]  o_GAIN;
  logic        o_OVR;
  logic        o_UNR;
  logic        o_overflow;
`ifdef ADC_RX_ERRCNT_EN
  logic [15:0] o_ERRCNT;
`endif

  adc_result_decoder #(
    .DEPTH   (DEPTH),
    .CFG_RST (8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_xferDone (i_xferDone),
    .i_TXDATA   (i_TXDATA),
    .i_RXDATA   (i_RXDATA),
    .i_resReady (i_resReady),
    .o_resValid (o_resValid),
    .o_RESULT   (o_RESULT),
    .o_CHAN     (o_CHAN),
    .o_GAIN     (o_GAIN),
    .o_OVR      (o_OVR),
    .o_UNR      (o_UNR),
    .o_overflow (o_overflow)
`ifdef ADC_RX_ERRCNT_EN
    ,
    .o_ERRCNT   (o_ERRCNT)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         val;
    logic [4:0] chan;
    logic [2:0] gain;
    bit         ovr;
    bit         unr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  bit          m_primed;
  logic [4:0]  m_chan;
  logic [2:0]  m_gain;
  bit          m_ovf;
  int unsigned m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Value of the 17-bit magnitude with SIG as an inverted sign, in plain integer terms.
  function automatic exp_t predict(input logic [31:0] rx);
    exp_t e;
    int   d;
    d      = int'(rx[28:12]);
    e.val  = rx[29] ? d : d - 131072;
    e.chan = m_chan;
    e.gain = m_gain;
    e.ovr  = (e.val >= 65536);
    e.unr  = (e.val < -65536);
    return e;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_primed = 0;
    m_chan   = '0;
    m_gain   = '0;
    m_ovf    = 0;
    m_err    = 0;
  endtask

  task automatic do_xfer(input logic [31:0] tx, input logic [31:0] rx);
    bit fmt_ok;
    fmt_ok = !rx[31] && !rx[30];
    if (!fmt_ok && m_err != 32'hFFFF) m_err++;
    if (m_primed && fmt_ok) begin
      if (exp_q.size() >= DEPTH && !i_resReady) m_ovf = 1;
      else exp_q.push_back(predict(rx));
    end
    if (tx[31:30] == 2'b10 && tx[29]) begin
      m_primed = 1;
      m_chan   = tx[28:24];
      if (tx[23]) m_gain = tx[18:16];
    end
    i_xferDone = 1'b1;
    i_TXDATA   = tx;
    i_RXDATA   = rx;
    @(posedge clk);
    #1;
    i_xferDone = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    i_resReady = 1'b1;
    while (exp_q.size() != 0 && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_valid_low"}, o_resValid, 0);
    i_resReady = 1'b0;
  endtask

  task automatic check_errcnt(input string name);
`ifdef ADC_RX_ERRCNT_EN
    check(name, o_ERRCNT, m_err);
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  always @(negedge clk) begin
    if (!rst && o_resValid && i_resReady) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL entry: got res=%0d with no entry expected", $signed(o_RESULT));
      end else begin
        mon_e = exp_q.pop_front();
        n_total++;
        if ($signed(o_RESULT) == mon_e.val && o_CHAN === mon_e.chan && o_GAIN === mon_e.gain &&
            o_OVR === mon_e.ovr && o_UNR === mon_e.unr)
          n_pass++;
        else
          $display("FAIL entry: got res=%0d ch=%b g=%b ovr=%b unr=%b, expected res=%0d ch=%b g=%b ovr=%b unr=%b",
                   $signed(o_RESULT), o_CHAN, o_GAIN, o_OVR, o_UNR,
                   mon_e.val, mon_e.chan, mon_e.gain, mon_e.ovr, mon_e.unr);
      end
    end
  end

  initial begin
    logic [31:0] tx;
    logic [31:0] rx;
    rst        = 1'b1;
    i_xferDone = 1'b0;
    i_TXDATA   = '0;
    i_RXDATA   = '0;
    i_resReady = 1'b0;
    model_reset();
    idle(3);
    rst = 1'b0;

    check("rst_valid", o_resValid, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_result", o_RESULT, 0);
    check("rst_chan", o_CHAN, 0);
    check("rst_gain", o_GAIN, 0);
    check("rst_flags", {o_OVR, o_UNR}, 0);
    check_errcnt("rst_errcnt");

    // First transfer is discarded; its command primes channel 00101 / gain 101.
    do_xfer(32'hA585_0000, 32'h2000_0000);
    check("unprimed_discard", o_resValid, 0);
    do_xfer(32'h8000_0000, 32'h2000_1000);
    check("first_valid", o_resValid, 1);
    check("first_result", o_RESULT, 18'h00001);
    check("first_chan", o_CHAN, 5'b00101);
    check("first_gain", o_GAIN, 3'b101);
    do_xfer(32'h8000_0000, 32'h1FFF_F000);
    do_xfer(32'h8000_0000, 32'h3000_0000);
    do_xfer(32'h8000_0000, 32'h8000_0000);
    check_errcnt("eoc_errcnt");
    check("eoc_no_push", exp_q.size(), 3);
    drain("directed");

    // Fill past capacity with the consumer stalled.
    for (int unsigned k = 0; k <= DEPTH; k++) begin
      if (k == DEPTH) check("full_no_overflow_yet", o_overflow, 0);
      rx = {3'b001, 17'(k + 10), 12'h0};
      do_xfer(32'hA000_0000 | (32'(k) << 24), rx);
    end
    check("overflow_set", o_overflow, 1);
    check("overflow_kept", exp_q.size(), DEPTH);
    drain("overflow");
    check("overflow_sticky", o_overflow, 1);

    // Randomised traffic with a randomly stalling consumer.
    for (int unsigned i = 0; i < 200; i++) begin
      tx = $urandom;
      if ($urandom_range(0, 9) != 0) tx[31:30] = 2'b10;
      rx = $urandom;
      if ($urandom_range(0, 6) != 0) rx[31:30] = 2'b00;
      i_resReady = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) idle(1);
      else do_xfer(tx, rx);
    end
    drain("random");
    check("random_overflow", o_overflow, 32'(m_ovf));
    check_errcnt("random_errcnt");

    // Reset with two entries pending.
    do_xfer(32'hA000_0000, 32'h2000_5000);
    do_xfer(32'h8000_0000, 32'h2000_6000);
    check("pre_rst_valid", o_resValid, 1);
    rst = 1'b1;
    model_reset();
    idle(1);
    rst = 1'b0;
    check("post_rst_valid", o_resValid, 0);
    check("post_rst_overflow", o_overflow, 0);
    check_errcnt("post_rst_errcnt");
    do_xfer(32'hA585_0000, 32'h2000_1000);
    check("post_rst_discard", o_resValid, 0);
    do_xfer(32'h8000_0000, 32'h3FFF_F000);
    check("post_rst_push", o_resValid, 1);
    drain("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
